// File: rtl/vpu_operand_fetch.sv
// Operand fetch stage: pops one decoded vector request, issues per-beat SRAM reads
// and streams the returned operand bundles to the execution stage.
module vpu_operand_fetch #(
    parameter int SRAM_R_PORT_CNT    = 3,
    parameter int OPERAND_ADDR_WIDTH = 10,
    parameter int VEC_LEN_LG2        = 5,
    parameter int ELEM_WIDTH         = 32,
    parameter int SRAM_RD_LAT        = 1,
    parameter int OBUF_DEPTH         = SRAM_RD_LAT + 2
) (
    input  logic                                     clk,
    input  logic                                     rst_n,
    input  logic                                     req_valid_i,
    input  logic [SRAM_R_PORT_CNT-1:0]               req_rvalid_i,
    input  logic [SRAM_R_PORT_CNT*OPERAND_ADDR_WIDTH-1:0] req_raddr_i,
    input  logic [VEC_LEN_LG2-1:0]                   req_vlen_i,
    input  logic [OPERAND_ADDR_WIDTH-1:0]            req_waddr_i,
    output logic                                     req_rden_o,
    output logic [SRAM_R_PORT_CNT-1:0]               sram_ren_o,
    output logic [SRAM_R_PORT_CNT*OPERAND_ADDR_WIDTH-1:0] sram_raddr_o,
    input  logic [SRAM_R_PORT_CNT*ELEM_WIDTH-1:0]    sram_rdata_i,
    output logic                                     op_valid_o,
    input  logic                                     op_ready_i,
    output logic [SRAM_R_PORT_CNT*ELEM_WIDTH-1:0]    op_data_o,
    output logic                                     op_last_o,
    output logic [OPERAND_ADDR_WIDTH-1:0]            op_waddr_o,
    output logic                                     busy_o
);
    localparam int P  = SRAM_R_PORT_CNT;
    localparam int AW = OPERAND_ADDR_WIDTH;
    localparam int DW = SRAM_R_PORT_CNT * ELEM_WIDTH;
    localparam int CW = $clog2(OBUF_DEPTH + 1);
    localparam int PW = $clog2(OBUF_DEPTH);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

    state_t                 r_state, w_nextState;
    logic [P-1:0]           r_rvalid;
    logic [P*AW-1:0]        r_raddr;
    logic [VEC_LEN_LG2-1:0] r_vlen, r_beat;
    logic [AW-1:0]          r_waddr;
    logic [CW-1:0]          r_credits, r_count;
    logic [SRAM_RD_LAT-1:0] r_tagValid, r_tagLast;
    logic [AW-1:0]          r_tagWaddr [SRAM_RD_LAT];
    logic [DW-1:0]          r_mem [OBUF_DEPTH];
    logic [OBUF_DEPTH-1:0]  r_memLast;
    logic [AW-1:0]          r_memWaddr [OBUF_DEPTH];
    logic [PW-1:0]          r_wrPtr, r_rdPtr;

    logic          w_accept, w_issue, w_lastBeat, w_push, w_pop;
    logic [DW-1:0] w_pushData;

    assign w_issue    = (r_state == ISSUE) && (r_credits != '0);
    assign w_lastBeat = (r_beat == r_vlen);
    assign w_push     = r_tagValid[SRAM_RD_LAT-1];
    assign w_pop      = op_valid_o && op_ready_i;
    assign req_rden_o = w_accept && rst_n;

    always_comb begin
        w_nextState = r_state;
        w_accept    = 1'b0;
        case (r_state)
            IDLE: begin
                if (req_valid_i && (r_count == '0)) begin
                    w_accept    = 1'b1;
                    w_nextState = ISSUE;
                end
            end
            ISSUE: if (w_issue && w_lastBeat) w_nextState = DRAIN;
            DRAIN: if (w_pop && op_last_o) w_nextState = IDLE;
            default: w_nextState = IDLE;
        endcase
    end

    always_comb begin
        sram_ren_o   = '0;
        sram_raddr_o = '0;
        w_pushData   = '0;
        if (w_issue) begin
            sram_ren_o = r_rvalid;
            for (int i = 0; i < P; i++)
                sram_raddr_o[i*AW +: AW] = r_raddr[i*AW +: AW] + AW'(r_beat);
        end
        // Unread lanes carry whatever the SRAM drives, so they are forced to zero here.
        for (int i = 0; i < P; i++)
            if (r_rvalid[i])
                w_pushData[i*ELEM_WIDTH +: ELEM_WIDTH] = sram_rdata_i[i*ELEM_WIDTH +: ELEM_WIDTH];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_rvalid   <= '0;
            r_raddr    <= '0;
            r_vlen     <= '0;
            r_waddr    <= '0;
            r_beat     <= '0;
            r_credits  <= CW'(OBUF_DEPTH);
            r_count    <= '0;
            r_wrPtr    <= '0;
            r_rdPtr    <= '0;
            r_tagValid <= '0;
            r_tagLast  <= '0;
            for (int k = 0; k < SRAM_RD_LAT; k++) r_tagWaddr[k] <= '0;
        end else begin
            r_state <= w_nextState;
            if (w_accept) begin
                r_rvalid <= req_rvalid_i;
                r_raddr  <= req_raddr_i;
                r_vlen   <= req_vlen_i;
                r_waddr  <= req_waddr_i;
                r_beat   <= '0;
            end else if (w_issue) begin
                r_beat <= r_beat + VEC_LEN_LG2'(1);
            end
            r_credits     <= r_credits - CW'(w_issue) + CW'(w_pop);
            r_tagValid[0] <= w_issue;
            r_tagLast[0]  <= w_issue && w_lastBeat;
            r_tagWaddr[0] <= r_waddr + AW'(r_beat);
            for (int k = 1; k < SRAM_RD_LAT; k++) begin
                r_tagValid[k] <= r_tagValid[k-1];
                r_tagLast[k]  <= r_tagLast[k-1];
                r_tagWaddr[k] <= r_tagWaddr[k-1];
            end
            if (w_push) r_wrPtr <= (r_wrPtr == PW'(OBUF_DEPTH - 1)) ? '0 : r_wrPtr + PW'(1);
            if (w_pop)  r_rdPtr <= (r_rdPtr == PW'(OBUF_DEPTH - 1)) ? '0 : r_rdPtr + PW'(1);
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
        end
    end

    // Credits reserve a slot for every issued read, so a push never finds the buffer full.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wrPtr]      <= w_pushData;
            r_memLast[r_wrPtr]  <= r_tagLast[SRAM_RD_LAT-1];
            r_memWaddr[r_wrPtr] <= r_tagWaddr[SRAM_RD_LAT-1];
        end
    end

    assign op_valid_o = (r_count != '0);
    assign op_data_o  = op_valid_o ? r_mem[r_rdPtr] : '0;
    assign op_last_o  = op_valid_o && r_memLast[r_rdPtr];
    assign op_waddr_o = op_valid_o ? r_memWaddr[r_rdPtr] : '0;
    assign busy_o     = (r_state != IDLE) || op_valid_o;
endmodule

// File: tb/tb_vpu_operand_fetch.sv
// Scoreboard bench for vpu_operand_fetch: a behavioural SRAM plus a queue of
// expected operand beats checked whenever the execution side accepts a beat.
module tb_vpu_operand_fetch;
    localparam int P = 3, AW = 10, VL = 5, EW = 32, LAT = 1, DEPTH = LAT + 2;

    typedef struct packed {
        logic [P*EW-1:0] data;
        logic            last;
        logic [AW-1:0]   waddr;
    } beat_t;

    logic            clk = 1'b0, rst_n = 1'b0;
    logic            req_valid_i = 1'b0, req_rden_o;
    logic [P-1:0]    req_rvalid_i = '0, sram_ren_o;
    logic [P*AW-1:0] req_raddr_i = '0, sram_raddr_o;
    logic [VL-1:0]   req_vlen_i = '0;
    logic [AW-1:0]   req_waddr_i = '0, op_waddr_o;
    logic [P*EW-1:0] sram_rdata_i, op_data_o;
    logic            op_valid_o, op_ready_i = 1'b0, op_last_o, busy_o;

    beat_t sbq[$];
    beat_t monExp;
    int    testsRun = 0, testsFailed = 0, popCount = 0;

    always #5 clk = ~clk;

    vpu_operand_fetch #(
        .SRAM_R_PORT_CNT(P), .OPERAND_ADDR_WIDTH(AW), .VEC_LEN_LG2(VL),
        .ELEM_WIDTH(EW), .SRAM_RD_LAT(LAT), .OBUF_DEPTH(DEPTH)
    ) dut (
        .clk(clk), .rst_n(rst_n), .req_valid_i(req_valid_i), .req_rvalid_i(req_rvalid_i),
        .req_raddr_i(req_raddr_i), .req_vlen_i(req_vlen_i), .req_waddr_i(req_waddr_i),
        .req_rden_o(req_rden_o), .sram_ren_o(sram_ren_o), .sram_raddr_o(sram_raddr_o),
        .sram_rdata_i(sram_rdata_i), .op_valid_o(op_valid_o), .op_ready_i(op_ready_i),
        .op_data_o(op_data_o), .op_last_o(op_last_o), .op_waddr_o(op_waddr_o), .busy_o(busy_o)
    );

    function automatic logic [EW-1:0] sramWord(input int port, input logic [AW-1:0] a);
        return {8'(port + 1), 8'hA5, 6'd0, a};
    endfunction

    // One-cycle SRAM; unread ports return junk so lane masking is visible.
    always @(posedge clk)
        for (int i = 0; i < P; i++)
            sram_rdata_i[i*EW +: EW] <= sram_ren_o[i] ? sramWord(i, sram_raddr_o[i*AW +: AW])
                                                      : (32'hBAD0_0000 | 32'(i));

    always @(negedge clk) begin
        if (rst_n && op_valid_o && op_ready_i) begin
            popCount++;
            testsRun++;
            if (sbq.size() == 0) begin
                testsFailed++;
                $display("[TB] FAIL unexpected_beat: got data=%h last=%b waddr=%h, expected no beat",
                         op_data_o, op_last_o, op_waddr_o);
            end else begin
                monExp = sbq.pop_front();
                if ({op_data_o, op_last_o, op_waddr_o} !== {monExp.data, monExp.last, monExp.waddr}) begin
                    testsFailed++;
                    $display("[TB] FAIL beat: got data=%h last=%b waddr=%h, expected data=%h last=%b waddr=%h",
                             op_data_o, op_last_o, op_waddr_o, monExp.data, monExp.last, monExp.waddr);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "[TB] watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyRequest(input logic [P-1:0] rv, input logic [P*AW-1:0] ra,
                                input int vlen, input logic [AW-1:0] wa);
        req_valid_i  = 1'b1;
        req_rvalid_i = rv;
        req_raddr_i  = ra;
        req_vlen_i   = VL'(vlen);
        req_waddr_i  = wa;
    endtask

    task automatic expectVector(input logic [P-1:0] rv, input logic [P*AW-1:0] ra,
                                input int vlen, input logic [AW-1:0] wa);
        beat_t b;
        for (int k = 0; k <= vlen; k++) begin
            b.data = '0;
            for (int i = 0; i < P; i++)
                if (rv[i]) b.data[i*EW +: EW] = sramWord(i, ra[i*AW +: AW] + AW'(k));
            b.last  = (k == vlen);
            b.waddr = wa + AW'(k);
            sbq.push_back(b);
        end
    endtask

    task automatic waitDrain(input int budget, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < budget; c++) begin
            if (sbq.size() == 0 && !busy_o) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) tick();
        @(negedge clk);
        testsRun++;
        if ({req_rden_o, sram_ren_o, sram_raddr_o, op_valid_o, op_data_o, op_last_o, op_waddr_o, busy_o} !== '0) begin
            testsFailed++;
            $display("[TB] FAIL reset_outputs: got rden=%b ren=%b raddr=%h valid=%b data=%h last=%b waddr=%h busy=%b, expected all 0",
                     req_rden_o, sram_ren_o, sram_raddr_o, op_valid_o, op_data_o, op_last_o, op_waddr_o, busy_o);
        end
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        testsRun++;
        if ({busy_o, op_valid_o} !== 2'b00) begin
            testsFailed++;
            $display("[TB] FAIL reset_release: got busy=%b valid=%b, expected 0 0", busy_o, op_valid_o);
        end
    endtask

    task automatic test_basic();
        logic [P-1:0]  expRen;
        logic [AW-1:0] expAddr;
        logic          expValid;
        bit            ok;
        op_ready_i = 1'b1;
        tick();
        applyRequest(3'b011, {10'h000, 10'h020, 10'h010}, 3, 10'h100);
        expectVector(3'b011, {10'h000, 10'h020, 10'h010}, 3, 10'h100);
        @(negedge clk);
        testsRun++;
        if (req_rden_o !== 1'b1) begin
            testsFailed++;
            $display("[TB] FAIL basic_rden_pulse: got %b, expected 1", req_rden_o);
        end
        for (int k = 1; k <= 8; k++) begin
            tick();
            req_valid_i = 1'b0;
            @(negedge clk);
            expRen   = (k <= 4) ? 3'b011 : 3'b000;
            expValid = (k >= 3) && (k <= 6);
            testsRun++;
            if ({req_rden_o, sram_ren_o, op_valid_o} !== {1'b0, expRen, expValid}) begin
                testsFailed++;
                $display("[TB] FAIL basic_cycle%0d: got rden=%b ren=%b valid=%b, expected rden=0 ren=%b valid=%b",
                         k, req_rden_o, sram_ren_o, op_valid_o, expRen, expValid);
            end
            if (k <= 4) begin
                expAddr = 10'h010 + AW'(k - 1);
                testsRun++;
                if (sram_raddr_o[AW-1:0] !== expAddr) begin
                    testsFailed++;
                    $display("[TB] FAIL basic_raddr0_cycle%0d: got %h, expected %h", k, sram_raddr_o[AW-1:0], expAddr);
                end
            end
        end
        waitDrain(40, ok);
        testsRun++;
        if (!ok) begin
            testsFailed++;
            $display("[TB] FAIL basic_drain: got pending=%0d busy=%b, expected 0 0", sbq.size(), busy_o);
        end
    endtask

    task automatic test_backpressure();
        int            issued = 0;
        bit            haveSnap = 1'b0, stableBad = 1'b0, ok;
        logic [P*EW+AW:0] snap = '0;
        op_ready_i = 1'b0;
        tick();
        applyRequest(3'b111, {10'h0C0, 10'h080, 10'h040}, 15, 10'h200);
        expectVector(3'b111, {10'h0C0, 10'h080, 10'h040}, 15, 10'h200);
        tick();
        req_valid_i = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (sram_ren_o != '0) issued++;
            if (op_valid_o) begin
                if (!haveSnap) begin
                    snap     = {op_data_o, op_last_o, op_waddr_o};
                    haveSnap = 1'b1;
                end else if ({op_data_o, op_last_o, op_waddr_o} !== snap) begin
                    stableBad = 1'b1;
                end
            end
            tick();
        end
        testsRun++;
        if (issued != DEPTH) begin
            testsFailed++;
            $display("[TB] FAIL bp_issue_limit: got %0d reads during stall, expected %0d", issued, DEPTH);
        end
        testsRun++;
        if ({haveSnap, stableBad} !== 2'b10) begin
            testsFailed++;
            $display("[TB] FAIL bp_stable: got valid_seen=%b changed=%b, expected 1 0", haveSnap, stableBad);
        end
        op_ready_i = 1'b1;
        waitDrain(100, ok);
        testsRun++;
        if (!ok) begin
            testsFailed++;
            $display("[TB] FAIL bp_drain: got pending=%0d busy=%b, expected 0 0", sbq.size(), busy_o);
        end
    endtask

    task automatic test_wrap();
        logic [AW-1:0] got [4];
        logic [AW-1:0] expAddr;
        int            n = 0;
        bit            ok;
        op_ready_i = 1'b1;
        tick();
        applyRequest(3'b001, {10'h000, 10'h000, 10'h3FE}, 3, 10'h3FE);
        expectVector(3'b001, {10'h000, 10'h000, 10'h3FE}, 3, 10'h3FE);
        tick();
        req_valid_i = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (sram_ren_o[0]) begin
                if (n < 4) got[n] = sram_raddr_o[AW-1:0];
                n++;
            end
            tick();
        end
        testsRun++;
        if (n != 4) begin
            testsFailed++;
            $display("[TB] FAIL wrap_read_count: got %0d, expected 4", n);
        end
        for (int j = 0; j < 4 && j < n; j++) begin
            expAddr = 10'h3FE + AW'(j);
            testsRun++;
            if (got[j] !== expAddr) begin
                testsFailed++;
                $display("[TB] FAIL wrap_addr%0d: got %h, expected %h", j, got[j], expAddr);
            end
        end
        waitDrain(40, ok);
        testsRun++;
        if (!ok) begin
            testsFailed++;
            $display("[TB] FAIL wrap_drain: got pending=%0d busy=%b, expected 0 0", sbq.size(), busy_o);
        end
    endtask

    task automatic test_single();
        bit seen = 1'b0, lastSeen = 1'b0;
        op_ready_i = 1'b1;
        tick();
        applyRequest(3'b100, {10'h155, 10'h000, 10'h000}, 0, 10'h0AA);
        expectVector(3'b100, {10'h155, 10'h000, 10'h000}, 0, 10'h0AA);
        tick();
        req_valid_i = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (op_valid_o && op_ready_i) begin
                seen     = 1'b1;
                lastSeen = op_last_o;
                break;
            end
            tick();
        end
        testsRun++;
        if ({seen, lastSeen} !== 2'b11) begin
            testsFailed++;
            $display("[TB] FAIL single_last: got seen=%b last=%b, expected 1 1", seen, lastSeen);
        end
        tick();
        @(negedge clk);
        testsRun++;
        if ({busy_o, op_valid_o, sbq.size() == 0} !== 3'b001) begin
            testsFailed++;
            $display("[TB] FAIL single_idle: got busy=%b valid=%b pending=%0d, expected 0 0 0",
                     busy_o, op_valid_o, sbq.size());
        end
    endtask

    task automatic test_back_to_back();
        logic [P-1:0]    rvTab [2] = '{3'b111, 3'b010};
        logic [P*AW-1:0] raTab [2] = '{{10'h300, 10'h200, 10'h100}, {10'h000, 10'h0F0, 10'h000}};
        int              vlTab [2] = '{2, 1};
        logic [AW-1:0]   waTab [2] = '{10'h050, 10'h060};
        int              idx = 0, rdenCount = 0;
        bit              advance, bad = 1'b0;
        op_ready_i = 1'b1;
        tick();
        applyRequest(rvTab[0], raTab[0], vlTab[0], waTab[0]);
        for (int c = 0; c < 80; c++) begin
            @(negedge clk);
            advance = 1'b0;
            if (req_rden_o) begin
                rdenCount++;
                if (busy_o || sbq.size() != 0 || idx > 1) bad = 1'b1;
                if (idx < 2) expectVector(rvTab[idx], raTab[idx], vlTab[idx], waTab[idx]);
                advance = 1'b1;
            end
            tick();
            if (advance) begin
                idx++;
                if (idx == 1) applyRequest(rvTab[1], raTab[1], vlTab[1], waTab[1]);
                else req_valid_i = 1'b0;
            end
            if (idx >= 2 && sbq.size() == 0 && !busy_o) break;
        end
        testsRun++;
        if (rdenCount != 2) begin
            testsFailed++;
            $display("[TB] FAIL b2b_rden_count: got %0d, expected 2", rdenCount);
        end
        testsRun++;
        if (bad) begin
            testsFailed++;
            $display("[TB] FAIL b2b_rden_early: got rden while busy or with beats pending, expected none");
        end
        testsRun++;
        if (sbq.size() != 0 || busy_o) begin
            testsFailed++;
            $display("[TB] FAIL b2b_drain: got pending=%0d busy=%b, expected 0 0", sbq.size(), busy_o);
        end
    endtask

    task automatic test_reset_mid();
        int base;
        bit anyValid = 1'b0, ok;
        op_ready_i = 1'b1;
        tick();
        applyRequest(3'b111, {10'h056, 10'h034, 10'h012}, 7, 10'h0F0);
        expectVector(3'b111, {10'h056, 10'h034, 10'h012}, 7, 10'h0F0);
        base = popCount;
        tick();
        req_valid_i = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk);
            if (popCount - base >= 2) break;
        end
        #1;
        testsRun++;
        if (popCount - base != 2) begin
            testsFailed++;
            $display("[TB] FAIL rmid_pre_beats: got %0d, expected 2", popCount - base);
        end
        rst_n = 1'b0;
        sbq.delete();
        @(posedge clk);
        @(negedge clk);
        testsRun++;
        if ({req_rden_o, sram_ren_o, op_valid_o, op_data_o, op_last_o, op_waddr_o, busy_o} !== '0) begin
            testsFailed++;
            $display("[TB] FAIL rmid_outputs: got rden=%b ren=%b valid=%b data=%h last=%b waddr=%h busy=%b, expected all 0",
                     req_rden_o, sram_ren_o, op_valid_o, op_data_o, op_last_o, op_waddr_o, busy_o);
        end
        tick();
        rst_n = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (op_valid_o) anyValid = 1'b1;
            tick();
        end
        testsRun++;
        if (anyValid) begin
            testsFailed++;
            $display("[TB] FAIL rmid_stale: got op_valid after reset, expected none");
        end
        base = popCount;
        applyRequest(3'b101, {10'h1E0, 10'h000, 10'h010}, 1, 10'h300);
        expectVector(3'b101, {10'h1E0, 10'h000, 10'h010}, 1, 10'h300);
        tick();
        req_valid_i = 1'b0;
        waitDrain(40, ok);
        testsRun++;
        if (!ok || popCount - base != 2) begin
            testsFailed++;
            $display("[TB] FAIL rmid_new_vector: got drained=%b beats=%0d, expected 1 2", ok, popCount - base);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_wrap();
        test_single();
        test_back_to_back();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end
endmodule

// File: doc/vpu_operand_fetch.md
Name: vpu_operand_fetch

Overview:
- Stage directly downstream of the VPU instruction decoder.
- Takes one decoded request: per-source read-valid flags, base read addresses, vector length and destination address.
- Pops that request from the decoder queue and walks the vector beat by beat, issuing parallel reads to the SRAM read ports.
- Buffers the fixed-latency read data and streams one operand bundle per beat to the execution stage with valid/ready flow control.

Parameters:
- SRAM_R_PORT_CNT, 3, number of source operand read ports.
- OPERAND_ADDR_WIDTH, 10, SRAM word address width.
- VEC_LEN_LG2, 5, width of the vector-length field.
- ELEM_WIDTH, 32, data width per port per beat.
- SRAM_RD_LAT, 1, cycles from sram_ren_o to sram_rdata_i valid (>=1).
- OBUF_DEPTH, SRAM_RD_LAT+2, output buffer entries.

Ports:
- clk, input, 1: clock. Single clock domain; all logic on the rising edge.
- rst_n, input, 1: reset. Synchronous, active-low.
- req_valid_i, input, 1: decoder has a request.
- req_rvalid_i, input, SRAM_R_PORT_CNT: per-port source used.
- req_raddr_i, input, SRAM_R_PORT_CNT*OPERAND_ADDR_WIDTH: per-port base address, port i at bits [i*AW +: AW].
- req_vlen_i, input, VEC_LEN_LG2: beat count minus 1.
- req_waddr_i, input, OPERAND_ADDR_WIDTH: destination base address.
- req_rden_o, output, 1: pop pulse to decoder queue.
- sram_ren_o, output, SRAM_R_PORT_CNT: per-port read enable.
- sram_raddr_o, output, SRAM_R_PORT_CNT*OPERAND_ADDR_WIDTH: per-port read address.
- sram_rdata_i, input, SRAM_R_PORT_CNT*ELEM_WIDTH: per-port read data.
- op_valid_o, output, 1: operand bundle valid.
- op_ready_i, input, 1: execution stage accepts.
- op_data_o, output, SRAM_R_PORT_CNT*ELEM_WIDTH: operand bundle.
- op_last_o, output, 1: final beat of the vector.
- op_waddr_o, output, OPERAND_ADDR_WIDTH: destination address for this beat.
- busy_o, output, 1: state != IDLE or buffer non-empty.

Behaviour:
- Reset (rst_n=0 at a clock edge):
  - All outputs 0, FSM to IDLE, beat and credit counters cleared, buffer emptied.
  - The SRAM read-valid pipeline is cleared, so in-flight reads are discarded.
  - Reset mid-vector aborts the vector; no partial beats appear after reset.
- FSM states IDLE, ISSUE, DRAIN:
  - IDLE: when req_valid_i=1 and the buffer is empty, req_rden_o=1 (combinational, exactly one cycle). Request fields are latched on that edge; next state is ISSUE. req_rden_o=0 in every other state.
  - ISSUE: one beat is issued per cycle when credits>0. An issued beat drives sram_ren_o=latched rvalid mask and sram_raddr_o[i]=base[i]+beat. After issuing beat vlen, next state is DRAIN.
  - DRAIN: when the beat with op_last_o is popped (op_valid_o & op_ready_i), next state is IDLE.
- Addresses wrap modulo 2^OPERAND_ADDR_WIDTH. op_waddr_o = waddr+beat, with the same wrap.
- Beat count = req_vlen_i+1 (range 1..2^VEC_LEN_LG2).
- Ports with rvalid=0: no SRAM read is issued, and their op_data_o lane is 0.
- All rvalid=0: beats are still emitted, with all-zero data.
- Credits:
  - Initial value OBUF_DEPTH.
  - Decrement on each issued beat; increment on each pop.
  - Issue is blocked at 0. This guarantees buffer space for every returning read, so there is no overflow and no data loss.
- Read return: a valid/last/waddr tag travels a SRAM_RD_LAT-deep shift register. sram_rdata_i is written into the buffer on the edge ending cycle issue+SRAM_RD_LAT.
- Buffer:
  - FIFO, first-word output registered.
  - Simultaneous push and pop is allowed at any occupancy, including full-with-pop and empty-with-push. Pushed data appears no earlier than the next cycle.
- Latency: accept at cycle T gives first sram_ren_o at T+1 and first op_valid_o at T+2+SRAM_RD_LAT.
- Throughput: 1 beat/cycle sustained with op_ready_i=1.
- Ordering: beats leave in address order; op_last_o is asserted only on beat vlen.
- op_data_o, op_last_o and op_waddr_o are held stable while op_valid_o=1 and op_ready_i=0.
- req_valid_i while not IDLE is ignored; the decoder entry is not popped.
- Next request: accepted in the first IDLE cycle after the last beat pops, which gives a 1-cycle bubble minimum.

Test Plan:
- Basic vector: rvalid=3'b011, raddr0=0x010, raddr1=0x020, vlen=3, waddr=0x100, op_ready=1, LAT=1.
  - req_rden_o is a single pulse at T.
  - sram_raddr port0 goes 0x010..0x013 at T+1..T+4; port2 ren stays 0.
  - Four op beats at T+3..T+6 with waddr 0x100..0x103; op_last only on the 4th; lane2=0.
- Backpressure: vlen=15, op_ready=0 for 10 cycles, then 1.
  - At most OBUF_DEPTH (3) reads are issued before the stall.
  - All 16 beats are delivered in order with data matching the SRAM model; op_data is stable during the stall.
- Wrap: raddr0=0x3FE, vlen=3 -> reads 0x3FE, 0x3FF, 0x000, 0x001.
- Single beat: vlen=0 -> exactly one beat with op_last=1; FSM returns to IDLE; busy_o falls the cycle after the pop.
- Back-to-back: req_valid_i held high with two queued requests.
  - Second req_rden_o occurs only in IDLE after the first vector's last pop.
  - No rden while busy; beats from the two vectors never interleave.
- Reset mid-vector: assert rst_n=0 after the 2nd beat of vlen=7.
  - All outputs are 0 next cycle, and no stale beats appear after release.
  - A new request (vlen=1) completes normally with 2 beats.
